// File: rtl/disp_pkg.sv
// Shared types, segment constants and the BCD-to-7-segment decoder for the
// calculator display path.
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BIN_W      = 16;
    localparam int BCD_W      = 20;
    localparam int SH_W       = BCD_W + BIN_W;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render as blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative shift-add-3 binary-to-BCD converter: one bit per clock, 16 shifts,
// then a single COMMIT cycle during which done is high and bcd is final.
module bin2bcd_iter
    import disp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BIN_W-1:0]  din,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    state_t          state;
    logic [SH_W-1:0] sh;
    logic [SH_W-1:0] sh_adj;
    logic [3:0]      cnt;

    // Correct every BCD nibble before the shift so it cannot exceed 9 after doubling.
    always_comb begin
        sh_adj = sh;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (sh[BIN_W + 4*i +: 4] >= 4'd5)
                sh_adj[BIN_W + 4*i +: 4] = sh[BIN_W + 4*i +: 4] + 4'd3;
        end
    end

    assign bcd = sh[SH_W-1:BIN_W];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sh    <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= {{BCD_W{1'b0}}, din};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sh  <= sh_adj << 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        done  <= 1'b1;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/display_driver.sv
// Converts a 16-bit value to BCD and time-multiplexes it onto four
// common-anode 7-segment digits with optional leading-zero blanking.
module display_driver
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_data,
    input  logic [15:0] data_in,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic                        done;
    logic [BCD_W-1:0]            bcd;
    logic [NUM_DIGITS-1:0][6:0]  dig;
    logic [NUM_DIGITS-1:0][6:0]  dig_n;
    logic                        ovf_n;
    logic                        lz;
    logic [3:0]                  nib;
    logic [PW-1:0]               pre;
    logic                        wrap;
    logic [1:0]                  idx;
    logic [1:0]                  idx_n;

    bin2bcd_iter u_conv (
        .clk   (clk),
        .reset (reset),
        .start (next_data),
        .din   (data_in),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    assign ovf_n = (bcd[BCD_W-1 -: 4] != 4'd0);

    // Walk from the most significant digit down so lz tracks "this and all higher are zero".
    always_comb begin
        dig_n = '0;
        lz    = 1'b1;
        nib   = '0;
        for (int i = NUM_DIGITS-1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib != 4'd0)
                lz = 1'b0;
            if (ovf_n)
                dig_n[i] = SEG_DASH;
            else if (BLANK_LZ != 0 && i != 0 && lz)
                dig_n[i] = SEG_BLANK;
            else
                dig_n[i] = bcd_to_seg(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dig <= {NUM_DIGITS{SEG_BLANK}};
            ovf <= 1'b0;
        end else if (done) begin
            dig <= dig_n;
            ovf <= ovf_n;
        end
    end

    assign wrap  = (pre == PW'(SCAN_DIV - 1));
    assign idx_n = wrap ? idx + 2'd1 : idx;

    // an and seg are loaded from the same next index so they always agree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre <= '0;
            idx <= '0;
            an  <= 4'b1110;
            seg <= SEG_BLANK;
        end else begin
            pre <= wrap ? '0 : pre + PW'(1);
            idx <= idx_n;
            an  <= ~(4'b0001 << idx_n);
            seg <= dig[idx_n];
        end
    end

endmodule

// File: doc/display_driver.md
Name: display_driver

Overview:
Consumer end of the calculator display path. It takes the 16-bit value selected by the display multiplexor and the `next_data` load strobe, and converts the value to BCD with an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes four common-anode 7-segment digits. It sits between the multiplexor/clock block and the board's segment/anode pins.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays enabled; range 2..2^20.
BLANK_LZ, 1, 1 = blank leading zeros (digit0 is always shown); 0 = show all four digits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
next_data  in  1  one-cycle load strobe; data_in is sampled when it is high
data_in  in  16  unsigned binary value to display
busy  out  1  conversion in progress; strobes are ignored while high
ovf  out  1  last committed value was >9999
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
an  out  4  digit enables, one-hot active-low; an[0] is the least significant digit

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; busy=0, ovf=0.
  - All four display registers are set to SEG_BLANK (7'h7F).
  - Scan index=0, prescaler=0, an=4'b1110, seg=7'h7F.
  - Reset in the middle of a conversion aborts it. No partial value is ever committed.
- FSM states and transitions:
  - IDLE: when next_data==1 at edge k, capture data_in into shift register sh[35:0]={20'b0,data_in}, set bit counter=0, go to CONV.
  - CONV: each edge, add 3 to every BCD nibble of sh[35:16] that is >=5, then shift the whole register left by 1 and increment the counter. The 16th shift happens at edge k+16, then go to COMMIT.
  - COMMIT (edge k+17): decode the BCD nibbles into the display registers, update ovf, return to IDLE.
- busy is a registered output: high after edge k through edge k+17, low from edge k+17 onward. A new strobe is accepted at edge k+18 at the earliest.
- next_data while busy: dropped, with no queueing and no side effects.
- Overflow: if the ten-thousands nibble is !=0, all four display registers are set to SEG_DASH (7'h3F) and ovf=1. Otherwise ovf=0.
- Leading-zero blanking (BLANK_LZ=1): digit i (i>=1) is blanked when it and every higher digit are 0. Value 0 shows a single '0' on digit0.
- Segment codes for 0..9, active-low: 40,79,24,30,19,12,02,78,00,10 (hex).
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the scan index advances 0→1→2→3→0.
  - an and seg are registered together from the same index, so they never disagree.
  - Scanning is independent of the FSM. A COMMIT that lands on the same edge as a scan step is visible on the next registered seg update; no glitch output is allowed.
- Widths: the shift register is 36 bits and the add-3 is applied per 4-bit nibble. The prescaler width is $clog2(SCAN_DIV). Nibbles cannot overflow: the max input 65535 yields 5 valid BCD digits.

Decomposition:
- Package disp_pkg:
  - FSM state enum {IDLE,CONV,COMMIT}.
  - Constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - Function bcd_to_seg(nibble) returning the active-low code.
- Sub-module bin2bcd_iter (the CONV/COMMIT datapath and counter, start/done handshake).
- display_driver instantiates bin2bcd_iter and contains the display registers, blanking, and scanner.

Test Plan:
1. Reset with SCAN_DIV=4: hold reset=0 for 3 cycles, release → an=1110, seg=7F, busy=0, ovf=0. an then advances every 4 cycles 1110→1101→1011→0111→1110.
2. Strobe next_data with data_in=1234 at edge k → busy high for edges k+1..k+17. After k+17, digits 3..0 show 79, 24, 30, 19; ovf=0.
3. data_in=7 → digits 3..1 show 7F (blanked), digit0 shows 78. data_in=0 → digit0 shows 40, others 7F. Repeat with BLANK_LZ=0: 0 shows 40 on all four digits.
4. data_in=10000, then 65535 → every digit shows 3F, ovf=1. Then data_in=9999 → every digit shows 10, ovf=0.
5. Load 1234, then strobe 4321 at busy cycle 5 → strobe ignored; display ends at 1234. Strobe 4321 at edge k+18 → accepted, display shows 4321.
6. Load 5678; assert reset=0 at busy cycle 8 → busy=0 and all digits 7F on the next edge, never 5678. A subsequent strobe with 42 → digit1 shows 19, digit0 shows 24.
